// File: rtl/snake_sound_pkg.sv
// Shared types for the Snakes audio path: oscillator mode, sequencer states,
// melody ids and note-table entries.
package snake_sound_pkg;

  typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;

  typedef enum logic [1:0] {
    MEL_EAT   = 2'd0,
    MEL_WIN   = 2'd1,
    MEL_CRASH = 2'd2
  } melody_t;

  typedef struct packed {
    logic [8:0] freq;
    logic [3:0] dur;
  } note_t;

  localparam logic [8:0] FREQ_RESET = 9'd440;

endpackage

// File: rtl/sound_sequencer_if.sv
// Game-control / oscillator side signals of the sound sequencer.
// master: game control and oscillator view; slave: the sequencer itself.
interface sound_sequencer_if;
  import snake_sound_pkg::*;

  logic       sound_en;
  logic       eat_evt;
  logic       win_evt;
  logic       crash_evt;
  logic [8:0] freq;
  MODE_TYPES  state;
  logic       playSound;
  logic       busy;

  modport master (
    output sound_en, eat_evt, win_evt, crash_evt,
    input  freq, state, playSound, busy
  );

  modport slave (
    input  sound_en, eat_evt, win_evt, crash_evt,
    output freq, state, playSound, busy
  );

endinterface

// File: rtl/sound_note_rom.sv
// Melody note table: {melody, index} -> {freq, dur}. Entries past the end of
// a melody read as dur=0, which the sequencer treats as the terminator.
module sound_note_rom
  import snake_sound_pkg::*;
(
  input  melody_t    mel,
  input  logic [2:0] idx,
  output note_t      note
);

  // Constant lookup; freq=0 with dur!=0 would be a rest.
  always_comb begin
    note = '{freq: 9'd0, dur: 4'd0};
    case ({mel, idx})
      {MEL_EAT,   3'd0}: note = '{freq: 9'd392, dur: 4'd1};
      {MEL_EAT,   3'd1}: note = '{freq: 9'd494, dur: 4'd1};
      {MEL_WIN,   3'd0}: note = '{freq: 9'd262, dur: 4'd1};
      {MEL_WIN,   3'd1}: note = '{freq: 9'd330, dur: 4'd1};
      {MEL_WIN,   3'd2}: note = '{freq: 9'd392, dur: 4'd1};
      {MEL_WIN,   3'd3}: note = '{freq: 9'd494, dur: 4'd3};
      {MEL_CRASH, 3'd0}: note = '{freq: 9'd330, dur: 4'd2};
      {MEL_CRASH, 3'd1}: note = '{freq: 9'd262, dur: 4'd2};
      {MEL_CRASH, 3'd2}: note = '{freq: 9'd196, dur: 4'd4};
      default:           note = '{freq: 9'd0,   dur: 4'd0};
    endcase
  end

endmodule

// File: rtl/sound_sequencer.sv
// Game-event melody player feeding the tone oscillator.
// Optional feature macro: SOUND_GAP_EN (inter-note gap of GAP_CYCLES instead
// of a single cycle).
//
//  state | meaning
//  IDLE  | no melody; state=OFF, busy=0, freq holds last value
//  PLAY  | note sounding (or rest) for dur*TICK_CYCLES cycles
//  GAP   | silence between notes; next note fetched when the timer expires
module sound_sequencer
  import snake_sound_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES  = 100_000
) (
  input  logic             clk,
  input  logic             nRst,
  sound_sequencer_if.slave bus
);

  localparam int TW = $clog2(15 * TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_W = TW'(TICK_CYCLES);
`ifdef SOUND_GAP_EN
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
`else
  localparam logic [TW-1:0] GAP_LOAD = '0;
`endif

  seq_state_t     state_q, state_d;
  melody_t        mel_q, mel_d;
  logic [2:0]     idx_q, idx_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [8:0]     freq_q, freq_d;
  MODE_TYPES      mode_q, mode_d;
  logic           play_q, play_d;
  logic           busy_q, busy_d;

  logic           evt_vld;
  melody_t        evt_mel;
  logic           start;
  melody_t        rom_mel;
  logic [2:0]     rom_idx;
  note_t          rom_note;

  // Priority encoder: crash > win > eat; losers in the same cycle are dropped.
  always_comb begin
    evt_vld = bus.crash_evt | bus.win_evt | bus.eat_evt;
    if (bus.crash_evt)    evt_mel = MEL_CRASH;
    else if (bus.win_evt) evt_mel = MEL_WIN;
    else                  evt_mel = MEL_EAT;
  end

  // A new melody starts from idle, or preempts only with strictly higher priority.
  assign start   = bus.sound_en & evt_vld & ((state_q == IDLE) | (evt_mel > mel_q));
  assign rom_mel = start ? evt_mel : mel_q;
  assign rom_idx = start ? 3'd0 : idx_q + 3'd1;

  sound_note_rom u_rom (
    .mel  (rom_mel),
    .idx  (rom_idx),
    .note (rom_note)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    mel_d   = mel_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    freq_d  = freq_q;
    mode_d  = mode_q;
    play_d  = play_q;
    busy_d  = busy_q;

    if (!bus.sound_en) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      timer_d = '0;
      mode_d  = OFF;
      play_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = PLAY;
      mel_d   = evt_mel;
      idx_d   = 3'd0;
      timer_d = TW'(rom_note.dur) * TICK_W - TW'(1);
      // Rests keep the previous freq so the oscillator never sees 0.
      if (rom_note.freq != 9'd0) freq_d = rom_note.freq;
      mode_d  = ON;
      play_d  = (rom_note.freq != 9'd0);
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (timer_q == '0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
            play_d  = 1'b0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        GAP: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if ((idx_q != 3'd7) && (rom_note.dur != 4'd0)) begin
            state_d = PLAY;
            idx_d   = idx_q + 3'd1;
            timer_d = TW'(rom_note.dur) * TICK_W - TW'(1);
            if (rom_note.freq != 9'd0) freq_d = rom_note.freq;
            play_d  = (rom_note.freq != 9'd0);
          end else begin
            state_d = IDLE;
            idx_d   = 3'd0;
            timer_d = '0;
            mode_d  = OFF;
            play_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      mel_q   <= MEL_EAT;
      idx_q   <= 3'd0;
      timer_q <= '0;
      freq_q  <= FREQ_RESET;
      mode_q  <= OFF;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mel_q   <= mel_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      freq_q  <= freq_d;
      mode_q  <= mode_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.freq      = freq_q;
  assign bus.state     = mode_q;
  assign bus.playSound = play_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer (TICK_CYCLES=4, GAP_CYCLES=3).
// Honours SOUND_GAP_EN for the expected gap length.
module tb_sound_sequencer;
  import snake_sound_pkg::*;

  localparam int TICK = 4;
  localparam int GAPC = 3;
`ifdef SOUND_GAP_EN
  localparam int GAP_LEN = GAPC;
`else
  localparam int GAP_LEN = 1;
`endif

  // Melody table as written in the datasheet: eat, win, crash.
  localparam int NF [3][4] = '{'{392, 494, 0, 0}, '{262, 330, 392, 494}, '{330, 262, 196, 0}};
  localparam int ND [3][4] = '{'{1, 1, 0, 0},     '{1, 1, 1, 3},         '{2, 2, 4, 0}};

  typedef struct packed {
    logic [8:0] freq;
    logic       on;
    logic       play;
    logic       busy;
  } smp_t;

  localparam smp_t RST_SMP = '{9'd440, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic nRst = 1'b0;
  sound_sequencer_if bus();

  sound_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAPC)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  smp_t exp_q[$];
  smp_t last;
  int   cur_mel;

  function automatic smp_t observe();
    smp_t s;
    s.freq = bus.freq;
    s.on   = logic'(bus.state);
    s.play = bus.playSound;
    s.busy = bus.busy;
    return s;
  endfunction

  // Expected per-cycle timeline of a whole melody: each note for dur*TICK
  // cycles, followed by a silent gap; rests keep the previous pitch.
  function automatic void append_melody(input int m);
    logic [8:0] f;
    smp_t s;
    f = last.freq;
    for (int i = 0; i < 4; i++) begin
      if (ND[m][i] == 0) break;
      if (NF[m][i] != 0) f = 9'(NF[m][i]);
      s = '{f, 1'b1, (NF[m][i] != 0), 1'b1};
      for (int k = 0; k < ND[m][i] * TICK; k++) exp_q.push_back(s);
      s = '{f, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < GAP_LEN; k++) exp_q.push_back(s);
    end
  endfunction

  task automatic check(input string tag, input smp_t exp);
    smp_t obs;
    obs = observe();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got freq=%0d state=%0b play=%0b busy=%0b, want freq=%0d state=%0b play=%0b busy=%0b",
             tag, obs.freq, obs.on, obs.play, obs.busy, exp.freq, exp.on, exp.play, exp.busy);
    end
  endtask

  // One clock: apply inputs, update the reference timeline, check at negedge.
  task automatic cycle(input string tag, input bit e, input bit w, input bit c, input bit en);
    int p;
    bus.eat_evt = e; bus.win_evt = w; bus.crash_evt = c; bus.sound_en = en;
    p = c ? 2 : (w ? 1 : (e ? 0 : -1));
    if (!en) begin
      exp_q.delete();
    end else if (p >= 0 && (!last.busy || p > cur_mel)) begin
      exp_q.delete();
      cur_mel = p;
      append_melody(p);
    end
    @(negedge clk);
    bus.eat_evt = 1'b0; bus.win_evt = 1'b0; bus.crash_evt = 1'b0;
    if (exp_q.size() > 0) last = exp_q.pop_front();
    else                  last = '{last.freq, 1'b0, 1'b0, 1'b0};
    check(tag, last);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic pl [20];
  logic on_v [20];
  int   fall_at, gap_cnt;
  bit   gap_on;

  initial begin
    bus.sound_en = 1'b1; bus.eat_evt = 1'b0; bus.win_evt = 1'b0; bus.crash_evt = 1'b0;
    last = RST_SMP;
    cur_mel = 0;
    repeat (2) @(negedge clk);
    check("reset", RST_SMP);
    nRst = 1'b1;
    @(negedge clk);
    check("reset_release", RST_SMP);

    // Eat melody end to end.
    cycle("eat_start", 1'b1, 1'b0, 1'b0, 1'b1);
    idle("eat_run", 4 * TICK + 2 * GAP_LEN + 3);

    // Crash and eat together: crash wins.
    cycle("crash_eat_same", 1'b1, 1'b0, 1'b1, 1'b1);
    idle("crash_run", 8 * TICK + 3 * GAP_LEN + 3);

    // Crash preempts eat during its second note; win during crash is ignored.
    cycle("eat_pre", 1'b1, 1'b0, 1'b0, 1'b1);
    idle("eat_pre_run", TICK + GAP_LEN + 2);
    cycle("crash_preempt", 1'b0, 1'b0, 1'b1, 1'b1);
    idle("crash_after_pre", 3);
    cycle("win_ignored", 1'b0, 1'b1, 1'b0, 1'b1);
    cycle("eat_ignored", 1'b1, 1'b0, 1'b0, 1'b1);
    idle("crash_drain", 8 * TICK + 3 * GAP_LEN);

    // Mute mid-win; events while muted do nothing.
    cycle("win_start", 1'b0, 1'b1, 1'b0, 1'b1);
    idle("win_run", 6);
    cycle("mute", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("mute_evt", 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("mute_evt2", 1'b0, 1'b1, 1'b0, 1'b0);
    idle("unmute", 3);

    // Gap width and state continuity between the two eat notes.
    cycle("gap_start", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      pl[i] = bus.playSound;
      on_v[i] = logic'(bus.state);
      cycle("gap_run", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    fall_at = -1;
    for (int i = 0; i < 19; i++)
      if (fall_at < 0 && pl[i] && !pl[i+1]) fall_at = i + 1;
    gap_cnt = 0;
    gap_on = 1'b1;
    if (fall_at >= 0)
      for (int i = fall_at; i < 20 && !pl[i]; i++) begin
        gap_cnt++;
        if (!on_v[i]) gap_on = 1'b0;
      end
    n_tests++;
    assert (gap_cnt === GAP_LEN) else begin
      n_fail++;
      $error("FAIL gap_width: got %0d cycles, want %0d", gap_cnt, GAP_LEN);
    end
    n_tests++;
    assert (gap_on === 1'b1) else begin
      n_fail++;
      $error("FAIL gap_state_on: got state low during gap, want ON");
    end

    // Asynchronous reset in the middle of a melody.
    cycle("win_for_rst", 1'b0, 1'b1, 1'b0, 1'b1);
    idle("win_for_rst_run", 5);
    #2 nRst = 1'b0;
    #1 check("async_rst", RST_SMP);
    exp_q.delete();
    last = RST_SMP;
    @(negedge clk);
    check("rst_hold", RST_SMP);
    nRst = 1'b1;
    idle("post_rst", 2);

    // Randomized events and mute against the reference timeline.
    for (int i = 0; i < 600; i++)
      cycle("random",
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 49) != 0));
    idle("final_drain", 8 * TICK + 3 * GAP_LEN + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
